// File: rtl/alu_pkg.sv
// Shared types and helpers for the add/subtract unit: operation codes, handshake states,
// and the signed saturation bound generator.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ACC = 2'd2,
    OP_LDA = 2'd3
  } op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int unsigned SAT_MAX_W = 64;

  // Most negative value when sign=1, most positive when sign=0, for a width-bit word.
  function automatic logic [SAT_MAX_W-1:0] sat_value(input logic sign, input int unsigned width);
    logic [SAT_MAX_W-1:0] msb;
    msb = SAT_MAX_W'(1) << (width - 1);
    return sign ? msb : (msb - SAT_MAX_W'(1));
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit adder; inv=1 turns it into a two's complement subtractor.
// cout is the raw carry (NOT borrow when subtracting); ovf is signed overflow.
module addsub_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             inv,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   full;

  assign b_x  = b ^ {WIDTH{inv}};
  assign full = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, inv};
  assign sum  = full[WIDTH-1:0];
  assign cout = full[WIDTH];
  assign ovf  = (a[WIDTH-1] == b_x[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/addsub_unit.sv
// Registered add/sub/accumulate unit, 1-cycle latency, single output register with valid/ready;
// in_ready_o drops only while a result is held and not being taken.
module addsub_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  op_e              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic             zero_o,
  output logic [WIDTH-1:0] acc_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, acc_q;
  logic             carry_q, ovf_q;

  logic [WIDTH-1:0] core_a, core_b, core_sum, sat_val;
  logic             core_inv, core_cout, core_ovf;
  logic [WIDTH-1:0] res_d;
  logic             carry_d, ovf_d;
  logic             accept, consume;

  assign out_valid_o = (state_q == ST_FULL);
  assign in_ready_o  = !out_valid_o || out_ready_i;
  assign accept      = in_valid_i && in_ready_o;
  assign consume     = out_valid_o && out_ready_i;

  // OP_ACC reuses the single adder with the accumulator on the A side.
  always_comb begin
    core_a   = a_i;
    core_b   = b_i;
    core_inv = 1'b0;
    case (op_i)
      OP_SUB:  core_inv = 1'b1;
      OP_ACC: begin
        core_a = acc_q;
        core_b = a_i;
      end
      default: ;
    endcase
  end

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a    (core_a),
    .b    (core_b),
    .inv  (core_inv),
    .sum  (core_sum),
    .cout (core_cout),
    .ovf  (core_ovf)
  );

  // On overflow the true result has the sign of operand A.
  assign sat_val = WIDTH'(sat_value(core_a[WIDTH-1], WIDTH));

  always_comb begin
    res_d   = core_sum;
    carry_d = core_cout;
    ovf_d   = core_ovf;
    if (op_i == OP_LDA) begin
      res_d   = a_i;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (SATURATE && core_ovf) begin
      res_d = sat_val;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (consume && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_EMPTY;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        result_q <= res_d;
        carry_q  <= carry_d;
        ovf_q    <= ovf_d;
        if (op_i == OP_ACC || op_i == OP_LDA) acc_q <= res_d;
      end
    end
  end

  assign result_o = result_q;
  assign carry_o  = carry_q;
  assign ovf_o    = ovf_q;
  assign zero_o   = (result_q == '0);
  assign acc_o    = acc_q;

endmodule

// File: tb/tb_addsub_unit.sv
// Directed and randomized-stream bench for addsub_unit (WIDTH=8, wrap and saturating instances).
module tb_addsub_unit;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, out_ready;
  op_e        op;
  logic [7:0] a, b;

  logic       in_ready, out_valid, carry, ovf, zero;
  logic [7:0] result, acc;
  logic       s_in_ready, s_out_valid, s_carry, s_ovf, s_zero;
  logic [7:0] s_result, s_acc;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       v;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_acc;

  always #5 clk = ~clk;

  addsub_unit #(.WIDTH(8), .SATURATE(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .a_i(a), .b_i(b), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .carry_o(carry), .ovf_o(ovf), .zero_o(zero), .acc_o(acc)
  );

  addsub_unit #(.WIDTH(8), .SATURATE(1'b1)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
    .op_i(op), .a_i(a), .b_i(b), .out_valid_o(s_out_valid), .out_ready_i(out_ready),
    .result_o(s_result), .carry_o(s_carry), .ovf_o(s_ovf), .zero_o(s_zero), .acc_o(s_acc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input op_e o, input logic [7:0] x, input logic [7:0] y);
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
  endtask

  // Reference built from integer arithmetic rather than an adder model.
  function automatic exp_t model(input op_e o, input logic [7:0] x, input logic [7:0] y,
                                 inout logic [7:0] acc_m);
    int   u, s;
    exp_t e;
    u = 0;
    s = 0;
    e = '0;
    case (o)
      OP_ADD: begin
        u = int'(x) + int'(y);
        s = int'($signed(x)) + int'($signed(y));
        e.c = (u > 255);
      end
      OP_SUB: begin
        u = int'(x) - int'(y);
        s = int'($signed(x)) - int'($signed(y));
        e.c = (x >= y);
      end
      OP_ACC: begin
        u = int'(acc_m) + int'(x);
        s = int'($signed(acc_m)) + int'($signed(x));
        e.c = (u > 255);
      end
      default: begin
        u = int'(x);
        s = 0;
        e.c = 1'b0;
      end
    endcase
    e.r = u[7:0];
    e.v = (s > 127) || (s < -128);
    if (o == OP_ACC || o == OP_LDA) acc_m = e.r;
    return e;
  endfunction

  initial begin
    int   sent;
    int   cyc;
    exp_t e;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = OP_ADD;
    a         = 8'h00;
    b         = 8'h00;

    // 1. Reset
    tick;
    tick;
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_acc",       acc,       0);
    check("rst_zero",      zero,      1);
    check("rst_in_ready",  in_ready,  1);
    check("rst_result",    result,    0);

    // 2. Arithmetic and flags
    drive(OP_ADD, 8'h7F, 8'h01);
    tick;
    check("add_ovf_valid", out_valid, 1);
    check("add_ovf_res",   result,    8'h80);
    check("add_ovf_ovf",   ovf,       1);
    check("add_ovf_carry", carry,     0);
    check("sat_pos_res",   s_result,  8'h7F);
    check("sat_pos_ovf",   s_ovf,     1);
    drive(OP_SUB, 8'h05, 8'h07);
    tick;
    check("sub_neg_res",   result,    8'hFE);
    check("sub_neg_carry", carry,     0);
    check("sub_neg_ovf",   ovf,       0);
    drive(OP_SUB, 8'h05, 8'h05);
    tick;
    check("sub_zero_res",   result,   8'h00);
    check("sub_zero_zero",  zero,     1);
    check("sub_zero_carry", carry,    1);
    drive(OP_ADD, 8'h80, 8'hFF);
    tick;
    check("add_negovf_res",   result,   8'h7F);
    check("add_negovf_carry", carry,    1);
    check("add_negovf_ovf",   ovf,      1);
    check("sat_neg_res",      s_result, 8'h80);

    // 3. Accumulator, back-to-back
    drive(OP_LDA, 8'h10, 8'h00);
    tick;
    check("lda_res",   result, 8'h10);
    check("lda_carry", carry,  0);
    drive(OP_ACC, 8'h20, 8'h00);
    tick;
    check("acc1_res", result, 8'h30);
    drive(OP_ACC, 8'hF0, 8'h00);
    tick;
    check("acc2_res",   result, 8'h20);
    check("acc2_acc",   acc,    8'h20);
    check("acc2_carry", carry,  1);

    // Full throughput: one result per cycle
    for (int i = 1; i <= 4; i++) begin
      drive(OP_ADD, 8'(i), 8'(i));
      tick;
      check("thru_valid", out_valid, 1);
      check("thru_res",   result,    32'(2 * i));
    end
    in_valid = 1'b0;
    tick;
    check("drain_valid", out_valid, 0);

    // 4. Backpressure
    out_ready = 1'b0;
    drive(OP_ADD, 8'h03, 8'h04);
    tick;
    check("bp_first_res", result, 8'h07);
    drive(OP_ADD, 8'h01, 8'h01);
    #1;
    check("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("bp_hold_res",   result,    8'h07);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_rdy",   in_ready,  0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", in_ready, 1);
    tick;
    check("bp_next_res",   result,    8'h02);
    check("bp_next_valid", out_valid, 1);
    in_valid = 1'b0;
    tick;
    check("bp_empty_valid", out_valid, 0);
    check("bp_keep_res",    result,    8'h02);
    check("bp_acc_kept",    acc,       8'h20);

    // 5. Random stream against the reference model
    m_acc = 8'h20;
    sent  = 0;
    cyc   = 0;
    while ((sent < 16 || sb.size() > 0) && cyc < 400) begin
      in_valid  = (sent < 16) && ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 1) == 1);
      op        = op_e'($urandom_range(0, 3));
      a         = 8'($urandom);
      b         = 8'($urandom);
      #1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("stream_extra", 1, 0);
        end else begin
          e = sb.pop_front();
          check("stream_res",   result, e.r);
          check("stream_carry", carry,  e.c);
          check("stream_ovf",   ovf,    e.v);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(op, a, b, m_acc));
        sent++;
      end
      tick;
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_done", (sent == 16) && (sb.size() == 0), 1);
    check("stream_acc",  acc, m_acc);

    // 6. Reset while full and stalled
    out_ready = 1'b0;
    drive(OP_LDA, 8'h55, 8'h00);
    tick;
    check("pre_rst_acc",   acc,       8'h55);
    check("pre_rst_valid", out_valid, 1);
    in_valid = 1'b0;
    tick;
    rst_n = 1'b0;
    tick;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_acc",   acc,       0);
    check("mid_rst_res",   result,    0);
    check("mid_rst_zero",  zero,      1);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick;
    check("post_rst_valid", out_valid, 0);
    check("post_rst_rdy",   in_ready,  1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
